seq_mult_shift_add: RTL and testbench

//  Parametrised sequential shift-add multiplier: next generation of our 4-bit array multiplier.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/twos_mag.sv | 21 ++
 rtl/seq_mult_shift_add.sv | 170 +++++++++++++++++
 tb/tb_seq_mult_shift_add.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   - FSM state encoding (2'd3 is unused and treated as idle by the FSM)
//   - prod_width(): product width for a given operand width
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StCalc  = ST_CALC,
        StDone  = ST_DONE,
        StRsvd  = 2'd3
    } state_e;

    // Product of two w-bit operands needs 2*w bits in either signedness.
    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/twos_mag.sv
// Magnitude/sign split of one operand.
//   in_val     in   WIDTH  raw operand
//   signed_md  in   1      1: in_val is two's complement, 0: unsigned
//   mag        out  WIDTH  |in_val| as an unsigned value
//   sign       out  1      1 when in_val is a negative two's-complement value
// The most-negative value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
module twos_mag #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             signed_md,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    always_comb begin
        sign = signed_md & in_val[WIDTH-1];
        mag  = sign ? (~in_val + WIDTH'(1)) : in_val;
    end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        ready for operands (idle only)
//   a, b       in   WIDTH    multiplicand, multiplier
//   signed_md  in   1        1: two's-complement operands/product, 0: unsigned
//   out_valid  out  1        product valid
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  a*b
//   busy       out  1        calculating or holding a result
// Operands are reduced to magnitudes on accept; the sign of the result is applied
// once, on the final calculation edge, so the datapath itself is purely unsigned.
module seq_mult_shift_add
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_md,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned PW    = prod_width(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  ma_q, ma_d;
    logic [WIDTH-1:0]  mb_q, mb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     product_q, product_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              sign_a, sign_b;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     acc_next;
    logic              last_iter;

    twos_mag #(
        .WIDTH     (WIDTH)
    ) u_mag_a (
        .in_val    (a),
        .signed_md (signed_md),
        .mag       (mag_a),
        .sign      (sign_a)
    );

    twos_mag #(
        .WIDTH     (WIDTH)
    ) u_mag_b (
        .in_val    (b),
        .signed_md (signed_md),
        .mag       (mag_b),
        .sign      (sign_b)
    );

    // Partial product for the current multiplier bit, aligned by the iteration count.
    always_comb begin
        addend    = mb_q[0] ? (PW'(ma_q) << cnt_q) : '0;
        acc_next  = acc_q + addend;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            StIdle: begin
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    state_d    = StCalc;
                    ma_d       = mag_a;
                    mb_d       = mag_b;
                    // Signs are already gated by signed_md inside twos_mag.
                    neg_d      = sign_a ^ sign_b;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            StCalc: begin
                acc_d = acc_next;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d     = StDone;
                    product_d   = neg_q ? (~acc_next + PW'(1)) : acc_next;
                    out_valid_d = 1'b1;
                end
            end

            StDone: begin
                // in_valid is deliberately not looked at here: a new operation can only
                // start from an idle cycle with in_ready already high.
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                // Unused encoding recovers to idle without producing output.
                state_d     = StIdle;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
module tb_seq_mult_shift_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       rst_n4, in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] prod4;

    // WIDTH=8 instance
    logic        rst_n8, in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    seq_mult_shift_add #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .signed_md (sm4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (prod4),
        .busy      (busy4)
    );

    seq_mult_shift_add #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .signed_md (sm8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (prod8),
        .busy      (busy8)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] q4[$];
    logic [15:0] q8[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiply, truncated to 2*w bits.
    function automatic logic [15:0] model(input int unsigned w, input logic [7:0] a,
                                          input logic [7:0] b, input bit sm);
        longint ai, bi, p, mask;
        mask = (longint'(1) << w) - 1;
        ai = longint'(a) & mask;
        bi = longint'(b) & mask;
        if (sm && a[w-1]) ai = ai - (longint'(1) << w);
        if (sm && b[w-1]) bi = bi - (longint'(1) << w);
        p = ai * bi;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit sm, input int hold);
        int lat;
        logic [15:0] exp;
        a4 = a; b4 = b; sm4 = sm; in_valid4 = 1'b1; out_ready4 = 1'b0;
        q4.push_back(model(4, {4'b0, a}, {4'b0, b}, sm));
        lat = 0;
        while (!in_ready4 && lat < 20) begin tick(); lat++; end
        tick();
        in_valid4 = 1'b0;
        a4 = ~a; b4 = ~b; sm4 = ~sm;
        check("busy_after_accept", busy4, 1);
        check("in_ready_calc", in_ready4, 0);
        lat = 0;
        while (!out_valid4 && lat < 20) begin tick(); lat++; end
        check("latency4", lat, 4);
        exp = q4[0];
        in_valid4 = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_product4", prod4, exp[7:0]);
            check("hold_out_valid4", out_valid4, 1);
            check("hold_in_ready4", in_ready4, 0);
        end
        exp = q4.pop_front();
        check("product4", prod4, exp[7:0]);
        // in_valid stays high across the completing edge: it must not be accepted.
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        in_valid4 = 1'b0;
        check("out_valid_drop4", out_valid4, 0);
        check("idle_in_ready4", in_ready4, 1);
        check("idle_busy4", busy4, 0);
        check("product_kept4", prod4, exp[7:0]);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm, input int hold);
        int lat;
        logic [15:0] exp;
        a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
        q8.push_back(model(8, a, b, sm));
        lat = 0;
        while (!in_ready8 && lat < 40) begin tick(); lat++; end
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            // Stray handshakes while busy must be ignored.
            out_ready8 = 1'($urandom_range(0, 1));
            in_valid8  = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            tick();
            lat++;
        end
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("latency8", lat, 8);
        for (int i = 0; i < hold; i++) tick();
        exp = q8.pop_front();
        check("product8", prod8, exp);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("out_valid_drop8", out_valid8, 0);
    endtask

    initial begin
        rst_n4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        rst_n8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_busy", busy4, 0);
        check("rst_product", prod4, 0);
        check("rst_product8", prod8, 0);
        rst_n4 = 1'b1;
        rst_n8 = 1'b1;
        tick();

        run4(4'd15, 4'd15, 1'b0, 0);   // 225
        run4(4'b1000, 4'b1000, 1'b1, 0); // -8 * -8 = 64
        run4(4'b1101, 4'd5, 1'b1, 1);  // -3 * 5 = -15
        run4(4'd0, 4'hF, 1'b0, 0);
        run4(4'd0, 4'hF, 1'b1, 0);
        run4(4'd7, 4'b1000, 1'b1, 2);  // 7 * -8 = -56
        run4(4'd9, 4'd6, 1'b0, 10);    // back-pressure

        // Reset in the middle of a calculation.
        a4 = 4'd7; b4 = 4'd3; sm4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        tick();
        rst_n4 = 1'b0;
        #1;
        check("midrst_in_ready", in_ready4, 1);
        check("midrst_out_valid", out_valid4, 0);
        check("midrst_busy", busy4, 0);
        check("midrst_product", prod4, 0);
        #2;
        rst_n4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_out_valid", out_valid4, 0);
            check("post_rst_busy", busy4, 0);
        end

        run4(4'd11, 4'd13, 1'b0, 0);   // 143

        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        end

        check("q4_empty", q4.size(), 0);
        check("q8_empty", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
